watchdog_timer_unit: RTL and testbench
======================================

// Module: watchdog_timer_unit
// PURPOSE
//  Liveness watchdog for the AM-radio FPGA datapath. Host/CPU must pulse heartbeat
//  periodically; if no heartbeat arrives within TIMEOUT_CYCLES clocks, triggered latches
//  high and downstream logic mutes the RF output and enters its safe state.
//  warning asserts earlier, at WARN_CYCLES, so software can log a late heartbeat.
// PARAMETERS
//  TIMEOUT_CYCLES  250_000_000  idle clocks until trip; legal range 2..2^32-1
//  WARN_CYCLES     200_000_000  idle clocks until warning; 1 <= WARN_CYCLES < TIMEOUT_CYCLES
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rstn         in   1   reset, synchronous, active-low
//  enable       in   1   1 = watchdog armed; 0 = counting suspended and cleared
//  heartbeat    in   1   liveness pet; level-sampled, any high cycle counts as one pet
//  force_reset  in   1   software clear of the watchdog (counter, warning, trip latch)
//  triggered    out  1   sticky timeout flag (registered)
//  warning      out  1   early-warning flag (registered)
//  count        out  32  current idle-cycle count (registered)
// BEHAVIOUR
//  - Reset (rstn=0 at edge): count=0, warning=0, triggered=0. All outputs are registers.
//  - Per-edge priority, highest first:
//    1 rstn=0        -> full clear, as above
//    2 force_reset=1 -> full clear, regardless of enable or triggered
//    3 enable=0      -> count=0, warning=0; triggered holds its value
//    4 triggered=1   -> count frozen at TIMEOUT_CYCLES, warning=1; heartbeat ignored
//    5 heartbeat=1   -> count=0, warning=0
//    6 otherwise     -> count=count+1
//  - warning and triggered are computed from the next count value:
//    warning   <= (next >= WARN_CYCLES)
//    triggered <= triggered | (next >= TIMEOUT_CYCLES)
//    Flags therefore change on the same edge as count.
//  - Latency: after reset release with enable=1, heartbeat=0:
//    count=k after k edges; warning rises on edge WARN_CYCLES; triggered on edge TIMEOUT_CYCLES.
//  - count saturates at TIMEOUT_CYCLES; never wraps.
//  - Arithmetic: 32-bit unsigned compares; no overflow by construction.
//  - Leaving triggered requires rstn=0 or force_reset=1. enable toggling does not clear it.
//  - A heartbeat on the edge where next would reach TIMEOUT_CYCLES wins: no trip.
//  - Mid-operation reset or force_reset restarts the count from 0 on the following edge.
// CONFIGURATION
//  WDT_FORMAL_EN defined:
//   - adds f_past_valid register plus embedded assert/cover properties:
//     count <= TIMEOUT_CYCLES
//     triggered -> warning unless enable=0
//     $past(rstn=0) -> all outputs 0
//     heartbeat clears count when not triggered
//     cover warning, cover triggered
//  WDT_FORMAL_EN undefined:
//   - no formal logic is synthesised; functional behaviour is identical.
// TESTING
//  All scenarios use TIMEOUT_CYCLES=8, WARN_CYCLES=5.
//  1 rstn=0 one cycle, then enable=1, heartbeat=0
//    -> count 1..8; warning=1 from count=5; triggered=1 at count=8, then stays.
//  2 heartbeat=1 for one cycle at count=6 -> count=0, warning=0 next edge; no trip by count=7.
//  3 after trip, heartbeat pulses -> triggered stays 1, count stays 8.
//    Then force_reset=1 -> all outputs 0; counting resumes from 1.
//  4 enable=0 at count=4 -> count=0, warning=0.
//    enable=0 after trip -> count=0, triggered stays 1.
//  5 rstn=0 concurrent with heartbeat and force_reset -> all outputs 0 next edge.
//  6 heartbeat on the edge count goes 7->8 -> count=0, triggered=0.

Source files
------------

// File: rtl/watchdog_timer_unit_if.sv
// Interface bundling the watchdog control inputs and status outputs.
// The master side (host/testbench) drives enable, heartbeat and force_reset.
// The slave side (watchdog_timer_unit) drives triggered, warning and count.
interface watchdog_timer_unit_if;
  logic        enable;
  logic        heartbeat;
  logic        force_reset;
  logic        triggered;
  logic        warning;
  logic [31:0] count;

  modport master (
    output enable,
    output heartbeat,
    output force_reset,
    input  triggered,
    input  warning,
    input  count
  );

  modport slave (
    input  enable,
    input  heartbeat,
    input  force_reset,
    output triggered,
    output warning,
    output count
  );
endinterface

// File: rtl/watchdog_timer_unit.sv
// Liveness watchdog: counts idle clocks since the last heartbeat. warning
// rises at WARN_CYCLES and the sticky triggered flag latches at
// TIMEOUT_CYCLES. Once tripped, count is frozen at TIMEOUT_CYCLES, and only
// rstn=0 or force_reset=1 clears the trip.
//
// Optional build macro: WDT_FORMAL_EN adds an f_past_valid register and
// embedded assert/cover properties. Leaving it undefined builds no formal
// logic, and the functional behaviour is the same either way.
module watchdog_timer_unit #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
  parameter logic [31:0] WARN_CYCLES    = 32'd200_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  watchdog_timer_unit_if.slave  wdt
);

  logic [31:0] count_q, count_d;
  logic        warning_q, warning_d;
  logic        triggered_q, triggered_d;
  logic [31:0] next_count;

  // Next-state computation, following the per-edge priority order
  // (reset is handled in the flop block).
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    next_count  = '0;
    count_d     = count_q;
    warning_d   = warning_q;
    triggered_d = triggered_q;

    if (wdt.force_reset) begin
      count_d     = '0;
      warning_d   = 1'b0;
      triggered_d = 1'b0;
    end else if (!wdt.enable) begin
      count_d   = '0;
      warning_d = 1'b0;
    end else if (triggered_q) begin
      count_d   = TIMEOUT_CYCLES;
      warning_d = 1'b1;
    end else begin
      // A heartbeat wins even on the edge that would reach the timeout.
      if (wdt.heartbeat) begin
        next_count = '0;
      end else if (count_q >= TIMEOUT_CYCLES) begin
        next_count = TIMEOUT_CYCLES;
      end else begin
        next_count = count_q + 32'd1;
      end
      count_d     = next_count;
      warning_d   = (next_count >= WARN_CYCLES);
      triggered_d = triggered_q | (next_count >= TIMEOUT_CYCLES);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all flops
    // update together from the pre-edge values.
    if (!rstn) begin
      count_q     <= '0;
      warning_q   <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      warning_q   <= warning_d;
      triggered_q <= triggered_d;
    end
  end

  assign wdt.count     = count_q;
  assign wdt.warning   = warning_q;
  assign wdt.triggered = triggered_q;

`ifdef WDT_FORMAL_EN
  logic f_past_valid;

  // Marks that at least one edge has passed, so $past values are meaningful.
  always_ff @(posedge clk) begin
    f_past_valid <= 1'b1;
  end

  a_count_bound : assert property (@(posedge clk)
    f_past_valid |-> (count_q <= TIMEOUT_CYCLES));

  a_trig_warn : assert property (@(posedge clk)
    (f_past_valid && $past(rstn) && $past(wdt.enable) && triggered_q)
      |-> warning_q);

  a_reset_clear : assert property (@(posedge clk)
    (f_past_valid && !$past(rstn))
      |-> (count_q == '0 && !warning_q && !triggered_q));

  a_hb_clear : assert property (@(posedge clk)
    (f_past_valid && $past(rstn) && $past(wdt.enable) && !$past(wdt.force_reset)
      && $past(wdt.heartbeat) && !$past(triggered_q))
      |-> (count_q == '0));

  c_warning   : cover property (@(posedge clk) warning_q);
  c_triggered : cover property (@(posedge clk) triggered_q);
`endif

endmodule

// File: tb/tb_watchdog_timer_unit.sv
// Directed testbench for watchdog_timer_unit with TIMEOUT_CYCLES=8 and
// WARN_CYCLES=5. Inputs change and outputs are sampled 1 ns after each
// rising edge, well away from the next active edge.
module tb_watchdog_timer_unit;
  localparam logic [31:0] T_CYC = 32'd8;
  localparam logic [31:0] W_CYC = 32'd5;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  watchdog_timer_unit_if wdt_if ();

  watchdog_timer_unit #(
    .TIMEOUT_CYCLES (T_CYC),
    .WARN_CYCLES    (W_CYC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .wdt  (wdt_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_count,
                           input logic e_warn, input logic e_trig);
    check({tag, ".count"}, wdt_if.count, e_count);
    check({tag, ".warning"}, {31'd0, wdt_if.warning}, {31'd0, e_warn});
    check({tag, ".triggered"}, {31'd0, wdt_if.triggered}, {31'd0, e_trig});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    wdt_if.enable      = 1'b0;
    wdt_if.heartbeat   = 1'b0;
    wdt_if.force_reset = 1'b0;

    // Scenario 1: reset, then free-run to trip
    step();
    check_all("reset", 32'd0, 1'b0, 1'b0);
    rstn = 1'b1;
    wdt_if.enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_all($sformatf("run%0d", k), k, (k >= 5), (k == 8));
    end
    step();
    check_all("sat1", 32'd8, 1'b1, 1'b1);
    step();
    check_all("sat2", 32'd8, 1'b1, 1'b1);

    // Scenario 3: heartbeat ignored after trip, then force_reset
    wdt_if.heartbeat = 1'b1;
    step();
    check_all("hb_tripped", 32'd8, 1'b1, 1'b1);
    wdt_if.heartbeat = 1'b0;
    step();
    check_all("hb_tripped2", 32'd8, 1'b1, 1'b1);
    wdt_if.force_reset = 1'b1;
    step();
    check_all("force_rst", 32'd0, 1'b0, 1'b0);
    wdt_if.force_reset = 1'b0;
    step();
    check_all("resume", 32'd1, 1'b0, 1'b0);

    // Scenario 2: heartbeat at count=6 clears, no trip by count=7
    for (int k = 2; k <= 6; k++) step();
    check_all("at6", 32'd6, 1'b1, 1'b0);
    wdt_if.heartbeat = 1'b1;
    step();
    check_all("hb_at6", 32'd0, 1'b0, 1'b0);
    wdt_if.heartbeat = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    check_all("at7", 32'd7, 1'b1, 1'b0);

    // Scenario 6: heartbeat on the 7->8 edge wins
    wdt_if.heartbeat = 1'b1;
    step();
    check_all("hb_edge", 32'd0, 1'b0, 1'b0);
    wdt_if.heartbeat = 1'b0;

    // Scenario 4: enable=0 mid-count, then after trip
    for (int k = 1; k <= 4; k++) step();
    check_all("at4", 32'd4, 1'b0, 1'b0);
    wdt_if.enable = 1'b0;
    step();
    check_all("dis_at4", 32'd0, 1'b0, 1'b0);
    step();
    check_all("dis_hold", 32'd0, 1'b0, 1'b0);
    wdt_if.enable = 1'b1;
    for (int k = 1; k <= 8; k++) step();
    check_all("trip2", 32'd8, 1'b1, 1'b1);
    wdt_if.enable = 1'b0;
    step();
    check_all("dis_trip", 32'd0, 1'b0, 1'b1);
    wdt_if.enable = 1'b1;
    step();
    check_all("reen_trip", 32'd8, 1'b1, 1'b1);

    // Scenario 5: reset concurrent with heartbeat and force_reset
    rstn = 1'b0;
    wdt_if.heartbeat   = 1'b1;
    wdt_if.force_reset = 1'b1;
    step();
    check_all("rst_combo", 32'd0, 1'b0, 1'b0);
    rstn = 1'b1;
    wdt_if.heartbeat   = 1'b0;
    wdt_if.force_reset = 1'b0;
    step();
    check_all("post_rst", 32'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
